// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the tick-paced UART transmitter.
//   state_e      : transmitter FSM state encoding (IDLE/START/DATA/PARITY/STOP)
//   LINE_IDLE    : level of the serial line between frames (mark)
//   START_LEVEL  : level of the start bit (space)
// PARITY is always part of the encoding so the state register width does not
// depend on the UART_TX_PARITY_EN build option.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_e;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage : uart_pkg

// File: rtl/uart_tx_shreg.sv
// -----------------------------------------------------------------------------
// uart_tx_shreg
// Load/shift register for the outgoing payload plus a saturating count of the
// data bits already shifted out.
//   i_clk, w_reset : clock and synchronous active-high reset
//   i_load         : capture i_data, clear the bit count
//   i_shift        : shift right by one (zero fill), count one more bit
//   i_data         : payload to capture
//   o_bit0         : bit currently at the line end of the register
//   o_bit1         : bit that becomes o_bit0 after the next shift
//   o_last         : the bit at o_bit0 is the final data bit of the frame
// -----------------------------------------------------------------------------
module uart_tx_shreg #(
  parameter int p_DATA_BITS = 8
) (
  input  logic                   i_clk,
  input  logic                   w_reset,
  input  logic                   i_load,
  input  logic                   i_shift,
  input  logic [p_DATA_BITS-1:0] i_data,
  output logic                   o_bit0,
  output logic                   o_bit1,
  output logic                   o_last
);

  localparam int               CNT_W    = $clog2(p_DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(p_DATA_BITS);

  logic [p_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (i_load) begin
      shreg_d = i_data;
      cnt_d   = '0;
    end else if (i_shift) begin
      shreg_d = {1'b0, shreg_q[p_DATA_BITS-1:1]};
      // Saturate: a stray extra shift can never wrap the count back to "first bit".
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the payload register is never read before a load, so it carries no
  // reset; only control state (the count) is reset.
  always_ff @(posedge i_clk) begin
    shreg_q <= shreg_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (w_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_bit0 = shreg_q[0];
  assign o_bit1 = shreg_q[1];
  assign o_last = (cnt_q == CNT_LAST);

endmodule : uart_tx_shreg

// File: rtl/uart_tick_tx.sv
// -----------------------------------------------------------------------------
// uart_tick_tx
// UART transmitter paced by an external one-cycle bit-rate strobe. Each frame
// is start bit, p_DATA_BITS data bits LSB first, optional parity, stop bit(s).
// The accept pulse is fed back to the period counter's reset so the first bit
// boundary lands exactly one tick period after the accept edge.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data
// (even, or odd when p_PARITY_ODD=1). Without it p_PARITY_ODD is ignored.
//   i_clk, w_reset : clock and synchronous active-high reset
//   i_tick         : bit-time strobe from the period counter
//   o_tick_sync    : restart request to the period counter (= accept)
//   i_valid/i_data : byte offered for transmission
//   o_ready        : idle, byte can be accepted this cycle
//   o_tx           : serial line, idle high, registered
//   o_busy         : frame in progress (~o_ready)
//   o_done         : one-cycle pulse after the final stop bit
// -----------------------------------------------------------------------------
module uart_tick_tx #(
  parameter int p_DATA_BITS  = 8,
  parameter int p_STOP_BITS  = 1,
  parameter int p_PARITY_ODD = 0
) (
  input  logic                   i_clk,
  input  logic                   w_reset,
  input  logic                   i_tick,
  output logic                   o_tick_sync,
  input  logic                   i_valid,
  input  logic [p_DATA_BITS-1:0] i_data,
  output logic                   o_ready,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_done
);

  import uart_pkg::*;

  if (p_DATA_BITS < 5 || p_DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tick_tx: p_DATA_BITS must be 5..9");
  end
  if (p_STOP_BITS != 1 && p_STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tick_tx: p_STOP_BITS must be 1 or 2");
  end
  if (p_PARITY_ODD != 0 && p_PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tick_tx: p_PARITY_ODD must be 0 or 1");
  end

  // Value of the stop counter on the last stop bit.
  localparam logic STOP_LAST = (p_STOP_BITS == 2);

  state_e state_q, state_d;
  logic   tx_q, tx_d;
  logic   done_q, done_d;
  logic   stop_cnt_q, stop_cnt_d;
  logic   accept, load, shift;
  logic   bit0, bit1, last;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  assign o_ready     = (state_q == IDLE);
  assign o_busy      = ~o_ready;
  // Reset wins over a coincident request so the counter restart stays quiet.
  assign accept      = i_valid & o_ready & ~w_reset;
  assign o_tick_sync = accept;
  assign o_tx        = tx_q;
  assign o_done      = done_q;

  uart_tx_shreg #(
    .p_DATA_BITS (p_DATA_BITS)
  ) u_shreg (
    .i_clk   (i_clk),
    .w_reset (w_reset),
    .i_load  (load),
    .i_shift (shift),
    .i_data  (i_data),
    .o_bit0  (bit0),
    .o_bit1  (bit1),
    .o_last  (last)
  );

  // tx_d is the level of the bit that starts on this edge, so the registered
  // line changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    stop_cnt_d = stop_cnt_q;
    load       = 1'b0;
    shift      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ticks while idle are ignored; an accept also discards a coincident tick.
        if (accept) begin
          state_d = START;
          tx_d    = START_LEVEL;
          load    = 1'b1;
        end
      end
      START: begin
        if (i_tick) begin
          state_d = DATA;
          tx_d    = bit0;
        end
      end
      DATA: begin
        if (i_tick) begin
          shift = 1'b1;
          if (last) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d    = STOP;
            tx_d       = LINE_IDLE;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            tx_d = bit1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (i_tick) begin
          state_d    = STOP;
          tx_d       = LINE_IDLE;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      STOP: begin
        if (i_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_reset) begin
      state_q    <= IDLE;
      tx_q       <= LINE_IDLE;
      done_q     <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the whole byte at load time, before any shifting.
  always_comb begin
    parity_d = parity_q;
    if (load) parity_d = (^i_data) ^ (p_PARITY_ODD != 0);
  end

  always_ff @(posedge i_clk) begin
    parity_q <= parity_d;
  end
`endif

endmodule : uart_tick_tx

// File: tb/tb_uart_tick_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tick_tx
// Two transmitters, each paced by its own period-4 counter whose reset is
// o_tick_sync | w_reset:
//   unit 0 : p_STOP_BITS=1, even parity (when parity is built in)
//   unit 1 : p_STOP_BITS=2, odd parity  (when parity is built in)
// Expected line waveforms come from a frame model: list of bit levels, each
// held for four clock cycles, o_done one cycle after the final stop bit.
// -----------------------------------------------------------------------------
module tb_uart_tick_tx;

  localparam int PERIOD = 4;

  typedef logic bitq_t[$];

  logic       clk;
  logic       rst;
  logic [1:0] tick, sync, valid, ready, tx, busy, done;
  logic [7:0] data [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic line_log [1:64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_unit
    logic [1:0] pcnt;
    always_ff @(posedge clk) begin
      if (rst || sync[g]) pcnt <= 2'd0;
      else                pcnt <= pcnt + 2'd1;
    end
    assign tick[g] = (pcnt == 2'(PERIOD - 1));

    uart_tick_tx #(
      .p_DATA_BITS  (8),
      .p_STOP_BITS  (g + 1),
      .p_PARITY_ODD (g)
    ) dut (
      .i_clk       (clk),
      .w_reset     (rst),
      .i_tick      (tick[g]),
      .o_tick_sync (sync[g]),
      .i_valid     (valid[g]),
      .i_data      (data[g]),
      .o_ready     (ready[g]),
      .o_tx        (tx[g]),
      .o_busy      (busy[g]),
      .o_done      (done[g])
    );
  end

  // Bit levels of one frame on unit u, in transmission order.
  function automatic bitq_t frame_bits(input int u, input logic [7:0] d);
    bitq_t q;
    q = {};
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    q.push_back((^d) ^ (u == 1));
`endif
    for (int s = 0; s < u + 1; s++) q.push_back(1'b1);
    return q;
  endfunction

  // Called right after the accept edge; checks every cycle through the o_done cycle.
  task automatic check_frame(input int u, input logic [7:0] d);
    bitq_t q;
    int    n;
    logic  exp_tx, exp_done;
    q = frame_bits(u, d);
    n = q.size() * PERIOD;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      line_log[k] = tx[u];
      exp_tx   = (k <= n) ? q[(k - 1) / PERIOD] : 1'b1;
      exp_done = (k == n + 1);
      n_checks++;
      if (tx[u] !== exp_tx) begin
        n_fail++;
        $display("FAIL tx u%0d byte %h cycle %0d: got %b expected %b", u, d, k, tx[u], exp_tx);
      end
      n_checks++;
      if (done[u] !== exp_done) begin
        n_fail++;
        $display("FAIL done u%0d byte %h cycle %0d: got %b expected %b", u, d, k, done[u], exp_done);
      end
      n_checks++;
      if (ready[u] !== exp_done || busy[u] !== !exp_done) begin
        n_fail++;
        $display("FAIL ready/busy u%0d byte %h cycle %0d: got %b/%b expected %b/%b",
                 u, d, k, ready[u], busy[u], exp_done, !exp_done);
      end
    end
  endtask

  task automatic send(input int u, input logic [7:0] d);
    @(negedge clk);
    valid[u] = 1'b1;
    data[u]  = d;
    #1;
    n_checks++;
    if (sync[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_sync on accept u%0d: got %b expected 1", u, sync[u]);
    end
    @(posedge clk);
    #1 valid[u] = 1'b0;
    check_frame(u, d);
    @(negedge clk);
    n_checks++;
    if (done[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL done width u%0d: got %b expected 0", u, done[u]);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 2'b00;
    data[0] = 8'h00;
    data[1] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if ({tx[u], ready[u], busy[u], done[u], sync[u]} !== 5'b11000) begin
        n_fail++;
        $display("FAIL reset values u%0d: got tx,rdy,busy,done,sync=%b expected 11000",
                 u, {tx[u], ready[u], busy[u], done[u], sync[u]});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_8n1();
    logic exp_a5 [10];
    exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    send(0, 8'hA5);
`ifndef UART_TX_PARITY_EN
    for (int i = 0; i < 10; i++) begin
      for (int j = 1; j <= PERIOD; j++) begin
        n_checks++;
        if (line_log[i * PERIOD + j] !== exp_a5[i]) begin
          n_fail++;
          $display("FAIL 8n1 A5 bit %0d cycle %0d: got %b expected %b",
                   i, j, line_log[i * PERIOD + j], exp_a5[i]);
        end
      end
    end
`endif
  endtask

  task automatic test_stop2();
    send(1, 8'h3C);
`ifndef UART_TX_PARITY_EN
    for (int k = 37; k <= 44; k++) begin
      n_checks++;
      if (line_log[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL stop2 cycle %0d: got %b expected 1", k, line_log[k]);
      end
    end
`endif
  endtask

  task automatic test_parity();
`ifdef UART_TX_PARITY_EN
    send(0, 8'h07);
    n_checks++;
    if (line_log[38] !== 1'b1) begin
      n_fail++;
      $display("FAIL even parity 07: got %b expected 1", line_log[38]);
    end
    send(1, 8'h07);
    n_checks++;
    if (line_log[38] !== 1'b0) begin
      n_fail++;
      $display("FAIL odd parity 07: got %b expected 0", line_log[38]);
    end
`endif
  endtask

  task automatic test_back_to_back(input int u);
    @(negedge clk);
    valid[u] = 1'b1;
    data[u]  = 8'h00;
    @(posedge clk);
    #1 data[u] = 8'hFF;   // offered while busy: must not disturb the frame
    check_frame(u, 8'h00);
    n_checks++;
    if (sync[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back accept in done cycle u%0d: got sync %b expected 1", u, sync[u]);
    end
    @(posedge clk);
    #1 valid[u] = 1'b0;
    check_frame(u, 8'hFF);
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    d = 8'($urandom);
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = d;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    repeat (18) @(negedge clk);   // second cycle of data bit 3
    n_checks++;
    if (tx[0] !== d[3]) begin
      n_fail++;
      $display("FAIL mid_reset bit3 before reset: got %b expected %b", tx[0], d[3]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({tx[0], ready[0], done[0], busy[0]} !== 4'b1100) begin
      n_fail++;
      $display("FAIL mid_reset after reset: got tx,rdy,done,busy=%b expected 1100",
               {tx[0], ready[0], done[0], busy[0]});
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (done[0] !== 1'b0 || tx[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_reset quiet cycle %0d: got done %b tx %b expected 0 1", k, done[0], tx[0]);
      end
    end
    send(0, ~d);
  endtask

  task automatic test_idle_tick();
    bit found;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_tick cycle %0d: got tx %b rdy %b busy %b expected 1 1 0",
                 k, tx[0], ready[0], busy[0]);
      end
    end
    found = 1'b0;
    for (int k = 0; k < 2 * PERIOD && !found; k++) begin
      @(negedge clk);
      if (tick[0] === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL idle_tick no tick within %0d cycles", 2 * PERIOD);
    end else begin
      valid[0] = 1'b1;      // accept coincides with a tick
      data[0]  = 8'h96;
      #1;
      n_checks++;
      if (sync[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_tick sync: got %b expected 1", sync[0]);
      end
      @(posedge clk);
      #1 valid[0] = 1'b0;
      check_frame(0, 8'h96);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 16; r++) begin
      int u;
      u = int'($urandom_range(1, 0));
      repeat ($urandom_range(5, 0)) @(negedge clk);
      send(u, 8'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_stop2();
    test_parity();
    test_back_to_back(0);
    test_back_to_back(1);
    test_mid_reset();
    test_idle_tick();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule : tb_uart_tick_tx
